// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry flop process
// WIDTH-bit operands LSB-first under a start/busy/done handshake.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [WIDTH-1:0] s_q,      s_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             sum_bit_s;
    logic             carry_out_s;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign sum_bit_s   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_out_s = maj3(a_sr_q[0], b_sr_q[0], carry_q);

    // Next-state, datapath and output-flag computation
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        s_d      = s_q;
        count_d  = count_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = A;
                    b_sr_d  = sub ? ~B : B;
                    carry_d = sub ? 1'b1 : Cin;
                    count_d = {CW{1'b0}};
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                carry_d               = carry_out_s;
                res_sr_d              = res_sr_q >> 1;
                res_sr_d[WIDTH-1]     = sum_bit_s;
                a_sr_d                = a_sr_q >> 1;
                b_sr_d                = b_sr_q >> 1;
                count_d               = count_q + CNT_ONE;
                if (count_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB slice
                    s_d     = res_sr_d;
                    cout_d  = carry_out_s;
                    ovf_d   = carry_q ^ carry_out_s;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= {WIDTH{1'b0}};
            b_sr_q   <= {WIDTH{1'b0}};
            res_sr_q <= {WIDTH{1'b0}};
            s_q      <= {WIDTH{1'b0}};
            count_q  <= {CW{1'b0}};
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            s_q      <= s_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n at WIDTH 8, 1 and 16 against an
// arithmetic reference model plus hand-computed vectors.
module tb_serial_adder_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v, sub_v, cin_v;
    logic [63:0] a_v [3];
    logic [63:0] b_v [3];
    logic [7:0]  s0;
    logic [0:0]  s1;
    logic [15:0] s2;
    logic        cout0, cout1, cout2, ovf0, ovf1, ovf2;
    logic        busy0, busy1, busy2, done0, done1, done2;
    logic        cmp_en;
    int          total = 0;
    int          bad   = 0;

    int          m_cnt  [3];
    logic [63:0] m_s    [3];
    logic        m_c    [3];
    logic        m_o    [3];
    logic [65:0] m_pend [3];

    serial_adder_n #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
        .A(a_v[0][7:0]), .B(b_v[0][7:0]), .Cin(cin_v[0]),
        .S(s0), .Cout(cout0), .ovf(ovf0), .busy(busy0), .done(done0));

    serial_adder_n #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
        .A(a_v[1][0:0]), .B(b_v[1][0:0]), .Cin(cin_v[1]),
        .S(s1), .Cout(cout1), .ovf(ovf1), .busy(busy1), .done(done1));

    serial_adder_n #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]),
        .A(a_v[2][15:0]), .B(b_v[2][15:0]), .Cin(cin_v[2]),
        .S(s2), .Cout(cout2), .ovf(ovf2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    function automatic int wid(input int d);
        return (d == 0) ? 8 : ((d == 1) ? 1 : 16);
    endfunction

    // Reference arithmetic: returns {ovf, cout, s}
    function automatic logic [65:0] calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic ci, input logic sb);
        logic [63:0] mask, am, bm, s;
        logic [64:0] full;
        logic        co, ov;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = a & mask;
        bm   = (sb ? ~b : b) & mask;
        full = {1'b0, am} + {1'b0, bm} + {64'd0, (sb ? 1'b1 : ci)};
        s    = full[63:0] & mask;
        co   = full[w];
        ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {ov, co, s};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic get(input int d, output logic [63:0] s, output logic c, output logic o,
                       output logic b, output logic dn);
        case (d)
            0: begin s = {56'd0, s0}; c = cout0; o = ovf0; b = busy0; dn = done0; end
            1: begin s = {63'd0, s1}; c = cout1; o = ovf1; b = busy1; dn = done1; end
            default: begin s = {48'd0, s2}; c = cout2; o = ovf2; b = busy2; dn = done2; end
        endcase
    endtask

    // Transaction-level model: an accepted op completes WIDTH+1 cycles later
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) begin
                m_cnt[d] <= 0;
                m_s[d]   <= 64'd0;
                m_c[d]   <= 1'b0;
                m_o[d]   <= 1'b0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (m_cnt[d] == 0) begin
                    if (start_v[d]) begin
                        m_cnt[d]  <= wid(d) + 1;
                        m_pend[d] <= calc(wid(d), a_v[d], b_v[d], cin_v[d], sub_v[d]);
                    end
                end else begin
                    if (m_cnt[d] == 2) begin
                        m_s[d] <= m_pend[d][63:0];
                        m_c[d] <= m_pend[d][64];
                        m_o[d] <= m_pend[d][65];
                    end
                    m_cnt[d] <= m_cnt[d] - 1;
                end
            end
        end
    end

    // Every-cycle comparison of all three instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 3; d++) begin
                logic [63:0] rs;
                logic        rc, ro, rb, rd;
                get(d, rs, rc, ro, rb, rd);
                chk($sformatf("cyc_s_%0d", d),    rs, m_s[d]);
                chk($sformatf("cyc_cout_%0d", d), {63'd0, rc}, {63'd0, m_c[d]});
                chk($sformatf("cyc_ovf_%0d", d),  {63'd0, ro}, {63'd0, m_o[d]});
                chk($sformatf("cyc_busy_%0d", d), {63'd0, rb}, {63'd0, (m_cnt[d] > 1)});
                chk($sformatf("cyc_done_%0d", d), {63'd0, rd}, {63'd0, (m_cnt[d] == 1)});
            end
        end
    end

    task automatic run_op(input int d, input logic [63:0] a, input logic [63:0] b,
                          input logic ci, input logic sb, input logic [63:0] es,
                          input logic ec, input logic eo, input string nm);
        int          lat, bcnt;
        bit          seen;
        logic [63:0] rs;
        logic        rc, ro, rb, rd;
        @(negedge clk);
        start_v[d] = 1'b1; a_v[d] = a; b_v[d] = b; cin_v[d] = ci; sub_v[d] = sb;
        seen = 1'b0; bcnt = 0; lat = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start_v[d] = 1'b0;
                a_v[d] = {$urandom, $urandom};
                b_v[d] = {$urandom, $urandom};
                cin_v[d] = ~ci;
                sub_v[d] = ~sb;
            end
            get(d, rs, rc, ro, rb, rd);
            if (rb) bcnt++;
            if (rd) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk({nm, "_seen_done"}, {63'd0, seen}, 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'(wid(d) + 1));
        chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(wid(d)));
        chk({nm, "_S"}, rs, es);
        chk({nm, "_Cout"}, {63'd0, rc}, {63'd0, ec});
        chk({nm, "_ovf"}, {63'd0, ro}, {63'd0, eo});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  fa_s, fa_c;
        logic [2:0]  ib;
        logic [63:0] rs, ra, rb16;
        logic        rc, ro, rb, rd, rsb, rci;
        logic [65:0] ex;
        int          d1, d2, ndone;

        fa_s = 8'b1001_0110;
        fa_c = 8'b1110_1000;
        cmp_en = 1'b0;
        rst = 1'b1;
        start_v = 3'b000; sub_v = 3'b000; cin_v = 3'b000;
        for (int d = 0; d < 3; d++) begin
            a_v[d] = 64'd0;
            b_v[d] = 64'd0;
        end
        repeat (2) @(negedge clk);
        get(0, rs, rc, ro, rb, rd);
        chk("reset_S", rs, 64'd0);
        chk("reset_flags", {60'd0, rc, ro, rb, rd}, 64'd0);
        cmp_en = 1'b1;
        #2 rst = 1'b0;

        // Pin the reference model with hand-computed values
        chk("model_ff_01", {62'd0, calc(8, 64'hFF, 64'h01, 1'b0, 1'b0)}, {62'd0, 2'b01, 64'h00});
        chk("model_80_m01", {62'd0, calc(8, 64'h80, 64'h01, 1'b0, 1'b1)}, {62'd0, 2'b11, 64'h7F});

        run_op(0, 64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(0, 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, "add_7f_01");
        run_op(0, 64'h05, 64'h07, 1'b1, 1'b1, 64'hFE, 1'b0, 1'b0, "sub_05_07");
        run_op(0, 64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b1, "sub_80_01");

        // start held high: second operands are ignored during busy, then taken 10 cycles later
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 64'h10; b_v[0] = 64'h20; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        d1 = 0; d2 = 0;
        for (int i = 1; i <= 60 && d2 == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a_v[0] = 64'h55; b_v[0] = 64'h0F; sub_v[0] = 1'b1;
            end
            if (d1 != 0 && i == d1 + 2) start_v[0] = 1'b0;
            get(0, rs, rc, ro, rb, rd);
            if (rd) begin
                if (d1 == 0) begin
                    d1 = i;
                    chk("hold_first_S", rs, 64'h30);
                    chk("hold_first_flags", {62'd0, rc, ro}, 64'd0);
                end else begin
                    d2 = i;
                    chk("hold_second_S", rs, 64'h46);
                    chk("hold_second_flags", {62'd0, rc, ro}, 64'd2);
                end
            end
        end
        chk("hold_first_latency", 64'(d1), 64'd9);
        chk("hold_spacing", 64'(d2 - d1), 64'd10);

        // Reset in the 4th SHIFT cycle discards the operation
        @(negedge clk);
        start_v[0] = 1'b1; a_v[0] = 64'h12; b_v[0] = 64'h34; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) start_v[0] = 1'b0;
        end
        get(0, rs, rc, ro, rb, rd);
        chk("pre_rst_busy", {63'd0, rb}, 64'd1);
        chk("pre_rst_S", rs, 64'h46);
        #2 rst = 1'b1;
        #1 get(0, rs, rc, ro, rb, rd);
        chk("rst_imm_S", rs, 64'd0);
        chk("rst_imm_flags", {60'd0, rc, ro, rb, rd}, 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            get(0, rs, rc, ro, rb, rd);
            if (rd) ndone++;
        end
        chk("rst_no_done", 64'(ndone), 64'd0);
        run_op(0, 64'h3C, 64'hC5, 1'b1, 1'b0, 64'h02, 1'b1, 1'b0, "after_rst");

        // WIDTH=1 full-adder truth table
        for (int i = 0; i < 8; i++) begin
            ib = 3'(i);
            run_op(1, {63'd0, ib[2]}, {63'd0, ib[1]}, ib[0], 1'b0,
                   {63'd0, fa_s[i]}, fa_c[i], ib[0] ^ fa_c[i], $sformatf("fa_%0d", i));
        end

        // WIDTH=16 random operations against the reference arithmetic
        for (int i = 0; i < 12; i++) begin
            ra   = 64'($urandom_range(0, 65535));
            rb16 = 64'($urandom_range(0, 65535));
            rci  = 1'($urandom_range(0, 1));
            rsb  = (i >= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            ex   = calc(16, ra, rb16, rci, rsb);
            run_op(2, ra, rb16, rci, rsb, ex[63:0], ex[64], ex[65], $sformatf("w16_%0d", i));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
